mem_stage: RTL

- Pipeline MEM stage, directly downstream of the EX stage's EX/MEM register.
- Holds a 64-word data RAM and performs loads/stores with a configurable wait-state FSM that stalls the pipe.
- Resolves branch-taken, captures the MEM/WB register, and drives the write-back value and address back to EX forwarding.

---
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage -- pipeline MEM stage.
//
// Sits directly downstream of the EX/MEM register. Holds a DEPTH-word data
// RAM, performs loads and stores, and uses a small wait-state FSM to stall
// the pipe for WAIT_CYCLES extra cycles per memory access. It also resolves
// branch-taken, captures the MEM/WB register and drives the write-back value
// back to EX forwarding and the register file.
//
// Optional build macro: MEM_RANGE_CHK_EN
//   When defined, accesses with ex_mem_result > DEPTH-1 do not write the RAM,
//   return read data 0, and set the sticky mem_addr_err output until reset.
//   When undefined, the word index is simply truncated with no check.
//
// Ports:
//   clk                 clock
//   rst_n               synchronous active-low reset
//   ex_mem_control_wb   [0] regwrite, [1] memtoreg
//   ex_mem_control_mem  [0] branch, [1] memread, [2] memwrite
//   ex_mem_result       ALU result / data address
//   ex_mem_store_data   store data
//   ex_mem_rd           destination register
//   ex_mem_zero         ALU zero flag
//   pc_src              branch taken (combinational)
//   mem_stall           freeze upstream pipeline registers while high
//   mem_wb_control_wb   registered WB control
//   mem_wb_rd           registered destination
//   mem_wb_read_data    registered load data
//   mem_wb_alu_result   registered ALU result
//   mem_addr_err        sticky out-of-range flag (MEM_RANGE_CHK_EN only)
//   wb_data             write-back value
//   wb_regwrite         write-back enable

module mem_stage #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ex_mem_control_wb,
    input  logic [2:0]  ex_mem_control_mem,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_zero,
    output logic        pc_src,
    output logic        mem_stall,
    output logic [1:0]  mem_wb_control_wb,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_alu_result,
`ifdef MEM_RANGE_CHK_EN
    output logic        mem_addr_err,
`endif
    output logic [31:0] wb_data,
    output logic        wb_regwrite
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    // The IDLE cycle that detects the access is already the first stall
    // cycle, so WAIT only needs to count the remaining WAIT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              memread;
    logic              memwrite;
    logic              access;
    logic              complete;
    logic              addr_ok;
    logic [AW-1:0]     idx;
    logic [31:0]       read_word;
    logic [31:0]       ram [DEPTH];

    assign memread  = ex_mem_control_mem[1];
    assign memwrite = ex_mem_control_mem[2];
    assign access   = memread | memwrite;
    assign idx      = ex_mem_result[AW-1:0];
    assign pc_src   = ex_mem_control_mem[0] & ex_mem_zero;

`ifdef MEM_RANGE_CHK_EN
    assign addr_ok  = (ex_mem_result < 32'(DEPTH));
`else
    assign addr_ok  = 1'b1;
`endif

    // Access completes on the first cycle it is present without a stall.
    assign complete = access & ~mem_stall;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && (WAIT_CYCLES > 0)) begin
                    state_d   = WAIT;
                    cnt_d     = CNT_LOAD;
                    mem_stall = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    mem_stall = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Held in reset the stage is idle; upstream must not see a stall.
        if (!rst_n) begin
            mem_stall = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Data RAM (contents survive reset; a write pending at reset is dropped)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && complete && memwrite && addr_ok) begin
            ram[idx] <= ex_mem_store_data;
        end
    end

    // Read sees the pre-write contents of a same-cycle store.
    assign read_word = addr_ok ? ram[idx] : '0;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wb_control_wb <= '0;
            mem_wb_rd         <= '0;
            mem_wb_read_data  <= '0;
            mem_wb_alu_result <= '0;
        end else if (mem_stall) begin
            mem_wb_control_wb <= '0;
            mem_wb_rd         <= '0;
        end else begin
            mem_wb_control_wb <= ex_mem_control_wb;
            mem_wb_rd         <= ex_mem_rd;
            mem_wb_alu_result <= ex_mem_result;
            if (memread) begin
                mem_wb_read_data <= read_word;
            end
        end
    end

`ifdef MEM_RANGE_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_err <= 1'b0;
        end else if (complete && !addr_ok) begin
            mem_addr_err <= 1'b1;
        end
    end
`endif

    assign wb_data     = mem_wb_control_wb[1] ? mem_wb_read_data : mem_wb_alu_result;
    assign wb_regwrite = mem_wb_control_wb[0];

endmodule
